// File: rtl/front_run_bot_pkg.sv
// Shared definitions for the front-running market-making bot: order field
// accessors, order packing and the decision FSM encoding.
package front_run_bot_pkg;

  localparam logic [13:0] BOT_QTY_DEF       = 14'd10;
  localparam int          SETTLE_CYCLES_DEF = 64;
  localparam int          MAX_PER_SIDE_DEF  = 16;
  localparam logic [15:0] MIN_PRICE_DEF     = 16'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL_BID,
    ST_EMIT_BID,
    ST_EVAL_ASK,
    ST_EMIT_ASK,
    ST_SETTLE
  } state_e;

  // Order word layout: {price[31:16], is_buy[15], is_bot[14], qty[13:0]}
  function automatic logic [15:0] order_price(input logic [31:0] order);
    return order[31:16];
  endfunction

  function automatic logic order_is_buy(input logic [31:0] order);
    return order[15];
  endfunction

  function automatic logic order_is_bot(input logic [31:0] order);
    return order[14];
  endfunction

  function automatic logic [13:0] order_qty(input logic [31:0] order);
    return order[13:0];
  endfunction

  function automatic logic [31:0] pack_order(input logic [15:0] price,
                                             input logic        is_buy,
                                             input logic        is_bot,
                                             input logic [13:0] qty);
    return {price, is_buy, is_bot, qty};
  endfunction

endpackage

// File: rtl/front_run_bot.sv
// Market-making bot: posts one tick inside the spread whenever the best level
// on a side is not already bot-owned, then settles while the book catches up.
module front_run_bot
  import front_run_bot_pkg::*;
#(
  parameter logic [13:0] BOT_QTY       = BOT_QTY_DEF,
  parameter int          SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int          MAX_PER_SIDE  = MAX_PER_SIDE_DEF,
  parameter logic [15:0] MIN_PRICE     = MIN_PRICE_DEF
) (
  input  logic        clk_engine,
  input  logic        rst_engine,
  input  logic        toggle_bot_enable,
  input  logic        freeze,
  input  logic [31:0] bid_root,
  input  logic        bid_valid,
  input  logic [31:0] ask_root,
  input  logic        ask_valid,
  output logic [31:0] order_out,
  output logic        order_valid,
  input  logic        order_ready,
  output logic        bot_enabled,
  output logic [4:0]  bid_sent,
  output logic [4:0]  ask_sent
);

  localparam int          TW        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]  MAX_SENT  = 5'(MAX_PER_SIDE);

  state_e        state_q, state_d;
  logic          enable_q, enable_d;
  logic [31:0]   order_q, order_d;
  logic          valid_q, valid_d;
  logic [4:0]    bid_sent_q, bid_sent_d;
  logic [4:0]    ask_sent_q, ask_sent_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_bid_q, last_bid_d;

  logic [15:0] bid_price, ask_price;
  logic        bid_ok, ask_ok, accept;

  assign bid_price = order_price(bid_root);
  assign ask_price = order_price(ask_root);
  assign accept    = valid_q && order_ready;

  // Price guards are ordered so that +1 / -1 never wraps at the 16-bit edges.
  assign bid_ok = bid_valid && !order_is_bot(bid_root) && (bid_price != 16'hFFFF) &&
                  (bid_sent_q < MAX_SENT) &&
                  (!ask_valid || ((bid_price + 16'd1) < ask_price));
  assign ask_ok = ask_valid && !order_is_bot(ask_root) && (ask_price > MIN_PRICE) &&
                  (ask_sent_q < MAX_SENT) &&
                  (!bid_valid || ((ask_price - 16'd1) > bid_price));

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q ^ toggle_bot_enable;
    order_d    = order_q;
    valid_d    = valid_q;
    bid_sent_d = bid_sent_q;
    ask_sent_d = ask_sent_q;
    timer_d    = timer_q;
    last_bid_d = last_bid_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_q && !freeze) state_d = ST_EVAL_BID;
      end
      ST_EVAL_BID: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (!freeze) begin
          if (bid_ok) begin
            order_d = pack_order(bid_price + 16'd1, 1'b1, 1'b1, BOT_QTY);
            valid_d = 1'b1;
            state_d = ST_EMIT_BID;
          end else begin
            state_d = ST_EVAL_ASK;
          end
        end
      end
      ST_EVAL_ASK: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (!freeze) begin
          if (ask_ok) begin
            order_d = pack_order(ask_price - 16'd1, 1'b0, 1'b1, BOT_QTY);
            valid_d = 1'b1;
            state_d = ST_EMIT_ASK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EMIT_BID, ST_EMIT_ASK: begin
        // An emitted order is never retracted; only the handshake moves us on.
        if (accept) begin
          valid_d    = 1'b0;
          timer_d    = TIMER_LOAD;
          last_bid_d = (state_q == ST_EMIT_BID);
          if (state_q == ST_EMIT_BID) begin
            if (bid_sent_q < MAX_SENT) bid_sent_d = bid_sent_q + 5'd1;
          end else begin
            if (ask_sent_q < MAX_SENT) ask_sent_d = ask_sent_q + 5'd1;
          end
          state_d = enable_q ? ST_SETTLE : ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          state_d = last_bid_q ? ST_EVAL_ASK : ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable_q && toggle_bot_enable) begin
      bid_sent_d = '0;
      ask_sent_d = '0;
    end
  end

  always_ff @(posedge clk_engine) begin
    if (rst_engine) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      order_q    <= '0;
      valid_q    <= 1'b0;
      bid_sent_q <= '0;
      ask_sent_q <= '0;
      timer_q    <= '0;
      last_bid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      order_q    <= order_d;
      valid_q    <= valid_d;
      bid_sent_q <= bid_sent_d;
      ask_sent_q <= ask_sent_d;
      timer_q    <= timer_d;
      last_bid_q <= last_bid_d;
    end
  end

  assign order_out   = order_q;
  assign order_valid = valid_q;
  assign bot_enabled = enable_q;
  assign bid_sent    = bid_sent_q;
  assign ask_sent    = ask_sent_q;

endmodule
